// File: rtl/ctrl_pkg.sv
// Shared state encoding and select priority encoder for the control bank.
// Optional undo support is enabled with CTRL_UNDO_EN.
package ctrl_pkg;

    typedef enum logic [1:0] {
        S_EDIT   = 2'd0,
        S_COMMIT = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    // Lowest set bit wins; zero input yields index 0.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ctrl_chan_reg.sv
// Per-channel committed setting and live mode storage.
// With CTRL_UNDO_EN a load also moves the old setting into prev.
module ctrl_chan_reg #(
    parameter int DATA_W = 8,
    parameter int MODE_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_d,
    input  logic              mode_we,
    input  logic [MODE_W-1:0] mode_d,
`ifdef CTRL_UNDO_EN
    output logic [DATA_W-1:0] prev,
`endif
    output logic [DATA_W-1:0] data,
    output logic [MODE_W-1:0] mode
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data <= '0;
            mode <= '0;
`ifdef CTRL_UNDO_EN
            prev <= '0;
`endif
        end else begin
            if (load) begin
                data <= load_d;
`ifdef CTRL_UNDO_EN
                prev <= data;
`endif
            end
            if (mode_we) mode <= mode_d;
        end
    end

endmodule

// File: rtl/ctrl_bank_fsm.sv
// Front-panel control router: select, stage and commit per-channel settings.
// Optional undo (swap with previous setting) is enabled with CTRL_UNDO_EN.
module ctrl_bank_fsm
    import ctrl_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int MODE_W = 2,
    parameter int SEL_W  = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          sel_req,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [MODE_W-1:0]          mode_in,
    input  logic                       enter,
`ifdef CTRL_UNDO_EN
    input  logic                       undo,
`endif
    output logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic [NUM_CH*MODE_W-1:0]   ch_mode,
    output logic [NUM_CH-1:0]          commit_pulse,
    output logic [NUM_CH-1:0]          dirty,
    output logic [SEL_W+MODE_W+DATA_W-1:0] status
);

    state_t            state;
    logic [SEL_W-1:0]  active_ch;
    logic [DATA_W-1:0] staged;
    logic              enter_q;
    logic              armed;

    logic [DATA_W-1:0] data_arr [NUM_CH];
    logic [MODE_W-1:0] mode_arr [NUM_CH];
    logic [NUM_CH-1:0] act_oh;
    logic [NUM_CH-1:0] load;
    logic [DATA_W-1:0] load_d;
    logic [DATA_W-1:0] cur_data;
    logic [MODE_W-1:0] cur_mode;
    logic [7:0]        sel_pad;
    logic              sel_any;
    logic              enter_rise;

`ifdef CTRL_UNDO_EN
    logic [DATA_W-1:0] prev_arr [NUM_CH];
    logic [DATA_W-1:0] cur_prev;
    logic              undo_q;
    logic              undo_go;
`endif

    assign sel_pad = 8'(sel_req);
    assign sel_any = |sel_req;
    // armed blocks a commit while enter is still held from reset
    assign enter_rise = enter & ~enter_q & armed;

    always_comb begin
        act_oh   = '0;
        cur_data = '0;
        cur_mode = '0;
`ifdef CTRL_UNDO_EN
        cur_prev = '0;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            if (active_ch == SEL_W'(k)) begin
                act_oh[k] = 1'b1;
                cur_data  = data_arr[k];
                cur_mode  = mode_arr[k];
`ifdef CTRL_UNDO_EN
                cur_prev  = prev_arr[k];
`endif
            end
        end
    end

    always_comb begin
        load   = '0;
        load_d = staged;
`ifdef CTRL_UNDO_EN
        undo_go = (state == S_EDIT) & undo & ~undo_q
                & ~sel_any & ~enter_rise;
`endif
        if (state == S_COMMIT) begin
            load = act_oh;
        end
`ifdef CTRL_UNDO_EN
        // reloading with prev swaps it with the current setting
        else if (undo_go) begin
            load   = act_oh;
            load_d = cur_prev;
        end
`endif
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ctrl_chan_reg #(
            .DATA_W (DATA_W),
            .MODE_W (MODE_W)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .load    (load[k]),
            .load_d  (load_d),
            .mode_we (act_oh[k]),
            .mode_d  (mode_in),
`ifdef CTRL_UNDO_EN
            .prev    (prev_arr[k]),
`endif
            .data    (data_arr[k]),
            .mode    (mode_arr[k])
        );
        assign ch_data[k*DATA_W +: DATA_W] = data_arr[k];
        assign ch_mode[k*MODE_W +: MODE_W] = mode_arr[k];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_EDIT;
            active_ch    <= '0;
            staged       <= '0;
            enter_q      <= 1'b0;
            armed        <= 1'b0;
            commit_pulse <= '0;
            dirty        <= '0;
            status       <= '0;
`ifdef CTRL_UNDO_EN
            undo_q       <= 1'b0;
`endif
        end else begin
            enter_q      <= enter;
            armed        <= armed | ~enter;
            commit_pulse <= load;
            dirty        <= (staged != cur_data) ? act_oh : '0;
            status       <= {active_ch, cur_mode, cur_data};
`ifdef CTRL_UNDO_EN
            undo_q       <= undo;
`endif
            unique case (state)
                S_EDIT: begin
                    if (sel_any) begin
                        active_ch <= SEL_W'(lowest_set(sel_pad));
                        staged    <= '0;
                    end else begin
                        staged <= data_in;
                        if (enter_rise) state <= S_COMMIT;
                    end
                end
                S_COMMIT: state <= S_HOLD;
                S_HOLD: begin
                    if (!enter) state <= S_EDIT;
                end
                default: state <= S_EDIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_bank_fsm.sv
// Directed bench for ctrl_bank_fsm (3 channels, 8-bit data, 2-bit mode).
// Undo vectors run only when CTRL_UNDO_EN is defined.
module tb_ctrl_bank_fsm;

    logic        clock;
    logic        reset;
    logic [2:0]  sel_req;
    logic [7:0]  data_in;
    logic [1:0]  mode_in;
    logic        enter;
`ifdef CTRL_UNDO_EN
    logic        undo;
`endif
    logic [23:0] ch_data;
    logic [5:0]  ch_mode;
    logic [2:0]  commit_pulse;
    logic [2:0]  dirty;
    logic [12:0] status;

    int n_chk;
    int n_err;
    int pulses;

    ctrl_bank_fsm #(
        .NUM_CH (3),
        .DATA_W (8),
        .MODE_W (2),
        .SEL_W  (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sel_req      (sel_req),
        .data_in      (data_in),
        .mode_in      (mode_in),
        .enter        (enter),
`ifdef CTRL_UNDO_EN
        .undo         (undo),
`endif
        .ch_data      (ch_data),
        .ch_mode      (ch_mode),
        .commit_pulse (commit_pulse),
        .dirty        (dirty),
        .status       (status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        reset   = 1'b0;
        sel_req = '0;
        data_in = '0;
        mode_in = '0;
        enter   = 1'b0;
`ifdef CTRL_UNDO_EN
        undo    = 1'b0;
`endif
        tick();
        tick();
        chk("rst_data", 32'(ch_data), 32'h0);
        chk("rst_pulse", 32'(commit_pulse), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_status", 32'(status), 32'h0);
        chk("idle_dirty", 32'(dirty), 32'h0);

        // select ch1, stage A5, press and hold enter for 20 cycles
        sel_req = 3'b010;
        data_in = 8'hA5;
        tick();
        sel_req = '0;
        tick();
        enter  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (commit_pulse != 0) pulses++;
            if (i == 0) chk("a5_early", 32'(commit_pulse), 32'h0);
            if (i == 1) begin
                chk("a5_data", 32'(ch_data), 32'h00A500);
                chk("a5_pulse", 32'(commit_pulse), 32'h2);
            end
        end
        chk("hold_pulses", 32'(pulses), 32'd1);

        enter   = 1'b0;
        data_in = 8'h3C;
        tick();
        tick();
        enter = 1'b1;
        tick();
        tick();
        chk("3c_data", 32'(ch_data), 32'h003C00);
        chk("3c_pulse", 32'(commit_pulse), 32'h2);
        enter = 1'b0;
        tick();
        tick();

        // select beats a simultaneous enter edge
        sel_req = 3'b110;
        enter   = 1'b1;
        tick();
        chk("sel_pulse0", 32'(commit_pulse), 32'h0);
        sel_req = '0;
        tick();
        chk("sel_pulse1", 32'(commit_pulse), 32'h0);
        chk("sel_dirty", 32'(dirty), 32'h2);
        chk("sel_status", 32'(status), 32'h043C);
        tick();
        chk("sel_pulse2", 32'(commit_pulse), 32'h0);
        enter = 1'b0;
        tick();

        // live mode and dirty on ch2
        sel_req = 3'b100;
        tick();
        sel_req = '0;
        mode_in = 2'b11;
        data_in = 8'h07;
        tick();
        chk("mode2", 32'(ch_mode), 32'h30);
        tick();
        chk("dirty2", 32'(dirty), 32'h4);
        chk("data2", 32'(ch_data), 32'h003C00);
        chk("status2", 32'(status), 32'h0B00);

        // reset while in S_COMMIT, enter still held across release
        enter = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("abort_data", 32'(ch_data), 32'h0);
        chk("abort_mode", 32'(ch_mode), 32'h0);
        chk("abort_pulse", 32'(commit_pulse), 32'h0);
        chk("abort_status", 32'(status), 32'h0);
        tick();
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (commit_pulse != 0) pulses++;
        end
        chk("held_pulses", 32'(pulses), 32'd0);
        chk("held_data", 32'(ch_data), 32'h0);
        enter = 1'b0;
        tick();
        enter = 1'b1;
        tick();
        tick();
        chk("rearm_data", 32'(ch_data), 32'h000007);
        chk("rearm_pulse", 32'(commit_pulse), 32'h1);
        enter = 1'b0;
        tick();
        tick();

`ifdef CTRL_UNDO_EN
        mode_in = 2'b00;
        data_in = 8'h11;
        tick();
        enter = 1'b1;
        tick();
        tick();
        enter = 1'b0;
        tick();
        data_in = 8'h22;
        tick();
        enter = 1'b1;
        tick();
        tick();
        chk("u22_data", 32'(ch_data), 32'h000022);
        enter = 1'b0;
        tick();
        tick();
        undo = 1'b1;
        tick();
        chk("undo_data", 32'(ch_data), 32'h000011);
        chk("undo_pulse", 32'(commit_pulse), 32'h1);
        tick();
        chk("undo_once", 32'(commit_pulse), 32'h0);
        chk("undo_hold", 32'(ch_data), 32'h000011);
        undo = 1'b0;
        tick();
        undo = 1'b1;
        tick();
        chk("redo_data", 32'(ch_data), 32'h000022);
        undo = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
